// File: rtl/norm_pkg.sv
// Shared definitions for the normalizing shifter: count-width helper and the
// result payload at the default geometry (32-bit mantissa, 10-bit exponent).
package norm_pkg;

  localparam int unsigned MANT_W = 32;
  localparam int unsigned EXP_W  = 10;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  typedef struct packed {
    logic [MANT_W-1:0]       mant;
    logic signed [EXP_W-1:0] exp;
    logic                    zero;
    logic                    uflow;
  } payload_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=1 counts from the MSB, MODE=0 from the LSB;
// empty_o flags an all-zero input (cnt_o is then 0).
module lzc
  import norm_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter bit          MODE  = 1'b1
) (
  input  logic [WIDTH-1:0]            in_i,
  output logic [cnt_width(WIDTH)-1:0] cnt_o,
  output logic                        empty_o
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (empty_o && in_i[MODE ? (WIDTH - 1 - i) : i]) begin
        cnt_o   = CntW'(i);
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/norm_shift.sv
// Two-stage elastic normalizer: S1 captures the operand and its leading-zero
// count, S2 captures the left-justified mantissa and the adjusted exponent.
module norm_shift
  import norm_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned EXP_WIDTH = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [WIDTH-1:0]            mant_i,
  input  logic signed [EXP_WIDTH-1:0] exp_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [WIDTH-1:0]            mant_o,
  output logic signed [EXP_WIDTH-1:0] exp_o,
  output logic                        zero_o,
  output logic                        uflow_o
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  logic                        s1Valid_q, s1Valid_d;
  logic [WIDTH-1:0]            s1Mant_q;
  logic signed [EXP_WIDTH-1:0] s1Exp_q;
  logic [CntW-1:0]             s1Cnt_q;
  logic                        s1Zero_q;

  logic                        s2Valid_q, s2Valid_d;
  logic [WIDTH-1:0]            mant_q, mant_d;
  logic signed [EXP_WIDTH-1:0] exp_q, exp_d;
  logic                        zero_q, zero_d;
  logic                        uflow_q, uflow_d;

  logic            s1Advance, s2Advance, s1Load, s2Load;
  logic [CntW-1:0] lzCnt;
  logic            lzEmpty;
  logic [EXP_WIDTH:0] expExt, cntExt, expDiff;

  lzc #(
    .WIDTH (WIDTH),
    .MODE  (1'b1)
  ) u_lzc (
    .in_i    (mant_i),
    .cnt_o   (lzCnt),
    .empty_o (lzEmpty)
  );

  // A stage may accept new contents when it is empty or is being drained this cycle.
  always_comb begin
    s2Advance = !s2Valid_q || ready_i;
    s1Advance = !s1Valid_q || s2Advance;
    s1Load    = s1Advance && valid_i && !flush_i;
    s2Load    = s2Advance && s1Valid_q && !flush_i;
    s1Valid_d = flush_i ? 1'b0 : (s1Advance ? valid_i : s1Valid_q);
    s2Valid_d = flush_i ? 1'b0 : (s2Advance ? s1Valid_q : s2Valid_q);
  end

  assign ready_o = s1Advance;

  // Exponent is adjusted one bit wider so a wrap past the most negative value is visible.
  always_comb begin
    expExt  = {s1Exp_q[EXP_WIDTH-1], s1Exp_q};
    cntExt  = (EXP_WIDTH + 1)'(s1Cnt_q);
    expDiff = expExt - cntExt;
    mant_d  = s1Mant_q << s1Cnt_q;
    zero_d  = s1Zero_q;
    exp_d   = s1Zero_q ? s1Exp_q : expDiff[EXP_WIDTH-1:0];
    uflow_d = !s1Zero_q && expDiff[EXP_WIDTH] && !expDiff[EXP_WIDTH-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1Valid_q <= 1'b0;
      s1Mant_q  <= '0;
      s1Exp_q   <= '0;
      s1Cnt_q   <= '0;
      s1Zero_q  <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      if (s1Load) begin
        s1Mant_q <= mant_i;
        s1Exp_q  <= exp_i;
        s1Cnt_q  <= lzCnt;
        s1Zero_q <= lzEmpty;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2Valid_q <= 1'b0;
      mant_q    <= '0;
      exp_q     <= '0;
      zero_q    <= 1'b0;
      uflow_q   <= 1'b0;
    end else begin
      s2Valid_q <= s2Valid_d;
      if (s2Load) begin
        mant_q  <= mant_d;
        exp_q   <= exp_d;
        zero_q  <= zero_d;
        uflow_q <= uflow_d;
      end
    end
  end

  assign valid_o = s2Valid_q;
  assign mant_o  = mant_q;
  assign exp_o   = exp_q;
  assign zero_o  = zero_q;
  assign uflow_o = uflow_q;

endmodule

// File: tb/tb_norm_shift.sv
// Self-checking bench for norm_shift: directed cases, throughput, stall,
// flush and mid-flight reset, with a scoreboard queue of expected payloads.
module tb_norm_shift;
  import norm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] mant_i = '0;
  logic [9:0]  exp_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] mant_o;
  logic [9:0]  exp_o;
  logic        zero_o;
  logic        uflow_o;

  int checks = 0;
  int errors = 0;
  int outCount = 0;
  payload_t sbQueue[$];

  norm_shift #(.WIDTH(32), .EXP_WIDTH(10)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .mant_i  (mant_i),
    .exp_i   (exp_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .mant_o  (mant_o),
    .exp_o   (exp_o),
    .zero_o  (zero_o),
    .uflow_o (uflow_o)
  );

  always #5 clk = ~clk;

  // Reference normalizer working on plain integers.
  function automatic payload_t model(input logic [31:0] m, input logic [9:0] e);
    payload_t r;
    int lz;
    int t;
    bit found;
    lz = 0;
    found = 1'b0;
    for (int b = 31; b >= 0; b--) begin
      if (!found && m[b]) found = 1'b1;
      else if (!found) lz++;
    end
    if (m == 32'd0) begin
      r.mant = '0; r.exp = e; r.zero = 1'b1; r.uflow = 1'b0;
    end else begin
      t = int'($signed(e)) - lz;
      r.mant = m << lz;
      r.exp = 10'(t);
      r.zero = 1'b0;
      r.uflow = (t < -512);
    end
    return r;
  endfunction

  // Scoreboard: handshakes are judged at the falling edge, mid-cycle.
  always @(negedge clk) begin
    payload_t got, exp;
    if (!rst_ni) begin
      sbQueue.delete();
    end else begin
      if (valid_o && ready_i) begin
        outCount++;
        got = '{mant: mant_o, exp: exp_o, zero: zero_o, uflow: uflow_o};
        checks++;
        if (sbQueue.size() == 0) begin
          errors++;
          $display("[TB] FAIL scoreboard unexpected result mant=%h exp=%0d, required none", mant_o, $signed(exp_o));
        end else begin
          exp = sbQueue.pop_front();
          if (got !== exp)
          begin
            errors++;
            $display("[TB] FAIL scoreboard got mant=%h exp=%0d zero=%b uflow=%b, required mant=%h exp=%0d zero=%b uflow=%b",
                     got.mant, $signed(got.exp), got.zero, got.uflow, exp.mant, $signed(exp.exp), exp.zero, exp.uflow);
          end
        end
      end
      if (flush_i) sbQueue.delete();
      else if (valid_i && ready_o) sbQueue.push_back(model(mant_i, exp_i));
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] m, input logic [9:0] e);
    valid_i = v;
    mant_i = m;
    exp_i = e;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((sbQueue.size() != 0 || valid_o) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sbQueue.size() != 0 || valid_o) begin
      errors++;
      $display("[TB] FAIL %s drain pending=%0d valid_o=%b, required 0 and 0", name, sbQueue.size(), valid_o);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({valid_o, mant_o, exp_o, zero_o, uflow_o} !== 45'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got valid=%b mant=%h exp=%h zero=%b uflow=%b, required all 0",
               valid_o, mant_o, exp_o, zero_o, uflow_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready got %b, required 1", ready_o);
    end
  endtask

  task automatic test_directed();
    logic [31:0] tMant[6];
    logic [9:0]  tExp[6];
    logic [31:0] rMant[6];
    logic [9:0]  rExp[6];
    logic        rZero[6];
    logic        rUflow[6];
    tMant[0] = 32'h0000_0F00; tExp[0] = 10'd5;       rMant[0] = 32'hF000_0000; rExp[0] = 10'(-15); rZero[0] = 0; rUflow[0] = 0;
    tMant[1] = 32'h0000_0000; tExp[1] = 10'(-3);     rMant[1] = 32'h0000_0000; rExp[1] = 10'(-3);  rZero[1] = 1; rUflow[1] = 0;
    tMant[2] = 32'h8000_0001; tExp[2] = 10'd7;       rMant[2] = 32'h8000_0001; rExp[2] = 10'd7;    rZero[2] = 0; rUflow[2] = 0;
    tMant[3] = 32'h0000_0001; tExp[3] = 10'(-500);   rMant[3] = 32'h8000_0000; rExp[3] = 10'd493;  rZero[3] = 0; rUflow[3] = 1;
    tMant[4] = 32'h7FFF_FFFF; tExp[4] = 10'(-512);   rMant[4] = 32'hFFFF_FFFE; rExp[4] = 10'd511;  rZero[4] = 0; rUflow[4] = 1;
    tMant[5] = 32'h0001_0000; tExp[5] = 10'd511;     rMant[5] = 32'h8000_0000; rExp[5] = 10'd496;  rZero[5] = 0; rUflow[5] = 0;
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      applyStimulus(1'b1, tMant[i], tExp[i]);
      @(posedge clk); #1;
      applyStimulus(1'b0, '0, '0);
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL directed%0d_early got valid_o=%b, required 0", i, valid_o);
      end
      @(posedge clk); #1;
      checks++;
      if ({valid_o, mant_o, exp_o, zero_o, uflow_o} !== {1'b1, rMant[i], rExp[i], rZero[i], rUflow[i]}) begin
        errors++;
        $display("[TB] FAIL directed%0d got valid=%b mant=%h exp=%0d zero=%b uflow=%b, required valid=1 mant=%h exp=%0d zero=%b uflow=%b",
                 i, valid_o, mant_o, $signed(exp_o), zero_o, uflow_o, rMant[i], $signed(rExp[i]), rZero[i], rUflow[i]);
      end
    end
    waitDrain("directed");
  endtask

  task automatic test_back_to_back();
    int badReady, badValid;
    badReady = 0;
    badValid = 0;
    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      applyStimulus(1'b1, (i % 5 == 4) ? 32'd0 : ($urandom >> $urandom_range(0, 31)), 10'($urandom));
      @(negedge clk);
      if (ready_o !== 1'b1) badReady++;
      if (i >= 2 && valid_o !== 1'b1) badValid++;
    end
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, '0);
    checks++;
    if (badReady != 0) begin
      errors++;
      $display("[TB] FAIL b2b_ready got %0d low cycles, required 0", badReady);
    end
    checks++;
    if (badValid != 0) begin
      errors++;
      $display("[TB] FAIL b2b_throughput got %0d bubbles, required 0", badValid);
    end
    waitDrain("b2b");
  endtask

  task automatic test_stall();
    int idx, startCount, unstable;
    bit sawLow, haveStall;
    logic [44:0] held;
    idx = 0; sawLow = 0; haveStall = 0; unstable = 0; held = '0;
    startCount = outCount;
    for (int c = 0; c < 60 && idx < 8; c++) begin
      @(posedge clk); #1;
      ready_i = !(c >= 3 && c <= 6);
      applyStimulus(1'b1, 32'h0000_1234 << c, 10'(c * 3 - 9));
      @(negedge clk);
      if (haveStall && {valid_o, mant_o, exp_o, zero_o, uflow_o} !== held) unstable++;
      haveStall = valid_o && !ready_i;
      held = {valid_o, mant_o, exp_o, zero_o, uflow_o};
      if (!ready_o) sawLow = 1'b1;
      if (valid_i && ready_o) idx++;
    end
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, '0);
    ready_i = 1'b1;
    waitDrain("stall");
    checks++;
    if (sawLow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_ready_low got %b, required 1", sawLow);
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("[TB] FAIL stall_stable got %0d changes, required 0", unstable);
    end
    checks++;
    if (outCount - startCount != 8) begin
      errors++;
      $display("[TB] FAIL stall_count got %0d results, required 8", outCount - startCount);
    end
  endtask

  task automatic test_flush();
    int startCount;
    bit sawValid;
    startCount = outCount;
    sawValid = 0;
    @(posedge clk); #1;
    ready_i = 1'b0;
    applyStimulus(1'b1, 32'h0000_00F0, 10'd20);
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h0300_0000, 10'd1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h0000_0003, 10'd2);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    applyStimulus(1'b0, '0, '0);
    ready_i = 1'b1;
    checks++;
    if ({valid_o, ready_o} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL flush_clear got valid_o=%b ready_o=%b, required 0 and 1", valid_o, ready_o);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (valid_o) sawValid = 1'b1;
    end
    checks++;
    if (sawValid || outCount != startCount) begin
      errors++;
      $display("[TB] FAIL flush_drop got valid_seen=%b results=%0d, required 0 and 0", sawValid, outCount - startCount);
    end
    applyStimulus(1'b1, 32'h0000_4000, 10'(-8));
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, '0);
    waitDrain("flush_after");
    checks++;
    if (outCount - startCount != 1) begin
      errors++;
      $display("[TB] FAIL flush_next got %0d results, required 1", outCount - startCount);
    end
  endtask

  task automatic test_reset_midflight();
    int startCount;
    bit sawValid;
    startCount = outCount;
    sawValid = 0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h0001_0001, 10'd3);
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h0000_0080, 10'd4);
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, '0);
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({valid_o, mant_o, exp_o, zero_o, uflow_o} !== 45'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs got valid=%b mant=%h exp=%h, required all 0", valid_o, mant_o, exp_o);
    end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (valid_o) sawValid = 1'b1;
    end
    checks++;
    if (sawValid || outCount != startCount || ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_mid_stale got valid_seen=%b results=%0d ready_o=%b, required 0, 0, 1",
               sawValid, outCount - startCount, ready_o);
    end
    applyStimulus(1'b1, 32'h00C0_0000, 10'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, '0);
    waitDrain("rst_after");
    checks++;
    if (outCount - startCount != 1) begin
      errors++;
      $display("[TB] FAIL rst_next got %0d results, required 1", outCount - startCount);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
